// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// datapath select codes and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset (R-type, lw, sw, beq, addi, j).
// Outputs decode from the current state; only FETCH strobes depend on mem_ready.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic [3:0]          state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrlDec;
    ctrl_t  ctrlOut;

    logic opRtype;
    logic opLw;
    logic opSw;
    logic opBeq;
    logic opAddi;
    logic opJ;
    logic opLegal;

    assign opRtype = (opcode == OPCODE_W'(OP_RTYPE));
    assign opLw    = (opcode == OPCODE_W'(OP_LW));
    assign opSw    = (opcode == OPCODE_W'(OP_SW));
    assign opBeq   = (opcode == OPCODE_W'(OP_BEQ));
    assign opAddi  = (opcode == OPCODE_W'(OP_ADDI));
    assign opJ     = (opcode == OPCODE_W'(OP_J));
    assign opLegal = opRtype | opLw | opSw | opBeq | opAddi | opJ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is only consulted in DECODE and MEM_ADDR, so it may change freely elsewhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opRtype)           state_d = S_R_EXEC;
                else if (opLw || opSw) state_d = S_MEM_ADDR;
                else if (opBeq)        state_d = S_BRANCH;
                else if (opAddi)       state_d = S_ADDI_EXEC;
                else if (opJ)          state_d = S_JUMP;
                else                   state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                if (opLw)      state_d = S_MEM_RD;
                else if (opSw) state_d = S_MEM_WR;
                else           state_d = S_FETCH;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_R_WB,
            S_MEM_WB,
            S_BRANCH,
            S_ADDI_WB,
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrlDec = '0;
        case (state_q)
            S_FETCH: begin
                ctrlDec.mem_read  = 1'b1;
                ctrlDec.alu_src_b = SRCB_FOUR;
                ctrlDec.alu_op    = ALU_ADD;
                ctrlDec.pc_source = PCSRC_ALU;
                ctrlDec.ir_write  = mem_ready;
                ctrlDec.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrlDec.alu_src_b  = SRCB_IMM_SH2;
                ctrlDec.alu_op     = ALU_ADD;
                ctrlDec.illegal_op = ~opLegal;
            end
            S_R_EXEC: begin
                ctrlDec.alu_src_a = 1'b1;
                ctrlDec.alu_src_b = SRCB_REGB;
                ctrlDec.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrlDec.reg_dst   = 1'b1;
                ctrlDec.reg_write = 1'b1;
            end
            S_MEM_ADDR,
            S_ADDI_EXEC: begin
                ctrlDec.alu_src_a = 1'b1;
                ctrlDec.alu_src_b = SRCB_IMM;
                ctrlDec.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrlDec.mem_read = 1'b1;
                ctrlDec.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrlDec.mem_to_reg = 1'b1;
                ctrlDec.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrlDec.mem_write = 1'b1;
                ctrlDec.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctrlDec.alu_src_a     = 1'b1;
                ctrlDec.alu_src_b     = SRCB_REGB;
                ctrlDec.alu_op        = ALU_SUB;
                ctrlDec.pc_write_cond = 1'b1;
                ctrlDec.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDI_WB: begin
                ctrlDec.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrlDec.pc_write  = 1'b1;
                ctrlDec.pc_source = PCSRC_JUMP;
            end
            default: ctrlDec = '0;
        endcase
    end

    // Reset silences every strobe immediately, before the clock edge lands the FSM in FETCH.
    assign ctrlOut = reset ? ctrl_t'('0) : ctrlDec;
    assign state   = reset ? S_FETCH : state_q;

    assign pc_write      = ctrlOut.pc_write;
    assign pc_write_cond = ctrlOut.pc_write_cond;
    assign i_or_d        = ctrlOut.i_or_d;
    assign mem_read      = ctrlOut.mem_read;
    assign mem_write     = ctrlOut.mem_write;
    assign ir_write      = ctrlOut.ir_write;
    assign mem_to_reg    = ctrlOut.mem_to_reg;
    assign reg_dst       = ctrlOut.reg_dst;
    assign reg_write     = ctrlOut.reg_write;
    assign alu_src_a     = ctrlOut.alu_src_a;
    assign alu_src_b     = ctrlOut.alu_src_b;
    assign alu_op        = ctrlOut.alu_op;
    assign pc_source     = ctrlOut.pc_source;
    assign illegal_op    = ctrlOut.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle queues its expected
// state and control word; a negedge monitor pops and compares.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    typedef struct {
        int         stepNo;
        logic [3:0] st;
        logic [16:0] ctrl;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        memReady;
    logic        pcWrite;
    logic        pcWriteCond;
    logic        iOrD;
    logic        memRead;
    logic        memWrite;
    logic        irWrite;
    logic        memToReg;
    logic        regDst;
    logic        regWrite;
    logic        aluSrcA;
    logic [1:0]  aluSrcB;
    logic [1:0]  aluOp;
    logic [1:0]  pcSource;
    logic        illegalOp;
    logic [3:0]  stateOut;

    exp_t sbQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   stepCount  = 0;

    logic [16:0] eZero, eFetchRdy, eFetchWait, eDecode, eDecodeIll, eRExec, eRWb;
    logic [16:0] eMemAddr, eMemRd, eMemWb, eMemWr, eBranch, eAddiEx, eAddiWb, eJump;

    multicycle_control #(.OPCODE_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (memReady),
        .pc_write      (pcWrite),
        .pc_write_cond (pcWriteCond),
        .i_or_d        (iOrD),
        .mem_read      (memRead),
        .mem_write     (memWrite),
        .ir_write      (irWrite),
        .mem_to_reg    (memToReg),
        .reg_dst       (regDst),
        .reg_write     (regWrite),
        .alu_src_a     (aluSrcA),
        .alu_src_b     (aluSrcB),
        .alu_op        (aluOp),
        .pc_source     (pcSource),
        .illegal_op    (illegalOp),
        .state         (stateOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic m2r, input logic rdst, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] psrc,
                                       input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
    endfunction

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy,
                                 input logic [3:0] expSt, input logic [16:0] expCtrl);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        opcode   = op;
        memReady = rdy;
        stepCount++;
        e.stepNo = stepCount;
        e.st     = expSt;
        e.ctrl   = expCtrl;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [16:0] act;
        act = {pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite, memToReg,
               regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};
        checkCount++;
        if (stateOut === e.st) passCount++;
        else $display("[TB] FAIL state step %0d: got %0d expected %0d", e.stepNo, stateOut, e.st);
        checkCount++;
        if (act === e.ctrl) passCount++;
        else $display("[TB] FAIL ctrl step %0d: got %b expected %b", e.stepNo, act, e.ctrl);
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
        end
    end

    initial begin
        reset    = 1'b1;
        opcode   = 6'b000000;
        memReady = 1'b1;

        eZero      = 17'd0;
        eFetchRdy  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        eFetchWait = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        eDecode    = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        eDecodeIll = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
        eRExec     = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        eRWb       = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        eMemAddr   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        eMemRd     = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        eMemWb     = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        eMemWr     = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        eBranch    = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        eAddiEx    = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        eAddiWb    = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
        eJump      = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);

        applyStimulus(1, 6'b000000, 1, 4'd0, eZero);
        applyStimulus(1, 6'b000000, 1, 4'd0, eZero);

        // R-type; opcode is changed during R_EXEC and must be ignored.
        applyStimulus(0, 6'b000000, 1, S_FETCH,  eFetchRdy);
        applyStimulus(0, 6'b000000, 1, S_DECODE, eDecode);
        applyStimulus(0, 6'b111111, 1, S_R_EXEC, eRExec);
        applyStimulus(0, 6'b111111, 1, S_R_WB,   eRWb);

        // FETCH stalled three cycles, then lw with a two-cycle memory stall.
        applyStimulus(0, 6'b111111, 0, S_FETCH,    eFetchWait);
        applyStimulus(0, 6'b111111, 0, S_FETCH,    eFetchWait);
        applyStimulus(0, 6'b111111, 0, S_FETCH,    eFetchWait);
        applyStimulus(0, 6'b100011, 1, S_FETCH,    eFetchRdy);
        applyStimulus(0, 6'b100011, 1, S_DECODE,   eDecode);
        applyStimulus(0, 6'b100011, 1, S_MEM_ADDR, eMemAddr);
        applyStimulus(0, 6'b100011, 0, S_MEM_RD,   eMemRd);
        applyStimulus(0, 6'b100011, 0, S_MEM_RD,   eMemRd);
        applyStimulus(0, 6'b100011, 1, S_MEM_RD,   eMemRd);
        applyStimulus(0, 6'b100011, 1, S_MEM_WB,   eMemWb);

        applyStimulus(0, 6'b000100, 1, S_FETCH,  eFetchRdy);
        applyStimulus(0, 6'b000100, 1, S_DECODE, eDecode);
        applyStimulus(0, 6'b000100, 1, S_BRANCH, eBranch);

        applyStimulus(0, 6'b111111, 1, S_FETCH,  eFetchRdy);
        applyStimulus(0, 6'b111111, 1, S_DECODE, eDecodeIll);

        applyStimulus(0, 6'b001000, 1, S_FETCH,     eFetchRdy);
        applyStimulus(0, 6'b001000, 1, S_DECODE,    eDecode);
        applyStimulus(0, 6'b001000, 1, S_ADDI_EXEC, eAddiEx);
        applyStimulus(0, 6'b001000, 1, S_ADDI_WB,   eAddiWb);

        applyStimulus(0, 6'b000010, 1, S_FETCH,  eFetchRdy);
        applyStimulus(0, 6'b000010, 1, S_DECODE, eDecode);
        applyStimulus(0, 6'b000010, 1, S_JUMP,   eJump);

        // sw stalled in MEM_WR, reset mid-wait, then a clean sw.
        applyStimulus(0, 6'b101011, 1, S_FETCH,    eFetchRdy);
        applyStimulus(0, 6'b101011, 1, S_DECODE,   eDecode);
        applyStimulus(0, 6'b101011, 1, S_MEM_ADDR, eMemAddr);
        applyStimulus(0, 6'b101011, 0, S_MEM_WR,   eMemWr);
        applyStimulus(1, 6'b101011, 0, 4'd0,       eZero);
        applyStimulus(0, 6'b101011, 0, S_FETCH,    eFetchWait);
        applyStimulus(0, 6'b101011, 1, S_FETCH,    eFetchRdy);
        applyStimulus(0, 6'b101011, 1, S_DECODE,   eDecode);
        applyStimulus(0, 6'b101011, 1, S_MEM_ADDR, eMemAddr);
        applyStimulus(0, 6'b101011, 1, S_MEM_WR,   eMemWr);
        applyStimulus(0, 6'b000000, 1, S_FETCH,    eFetchRdy);

        repeat (3) @(posedge clk);
        if (sbQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode field width.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  OPCODE_W  instruction opcode from the instruction register, valid from DECODE onward.
REQ-005 SHALL have port mem_ready  input  1  memory completion for the current read or write.
REQ-006 SHALL have port pc_write  output  1  unconditional PC load.
REQ-007 SHALL have port pc_write_cond  output  1  PC load qualified by ALU zero (branch).
REQ-008 SHALL have port i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 SHALL have ports mem_read, mem_write  output  1 each  memory strobes.
REQ-010 SHALL have port ir_write  output  1  instruction register load.
REQ-011 SHALL have ports mem_to_reg, reg_dst, reg_write  output  1 each  register-file writeback controls.
REQ-012 SHALL have port alu_src_a  output  1  ALU A select: 0 = PC, 1 = regA.
REQ-013 SHALL have port alu_src_b  output  2  ALU B select: 00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-014 SHALL have port alu_op  output  2  ALU operation: 00 = add, 01 = subtract, 10 = use funct field.
REQ-015 SHALL have port pc_source  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-016 SHALL have port illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-017 SHALL have port state  output  4  current state, for debug.

Function
REQ-018 SHALL implement a Moore FSM; every output SHALL be a function of state only, except ir_write and pc_write in FETCH, which SHALL be gated by mem_ready.
REQ-019 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; the FSM SHALL hold in FETCH while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode: 000000 -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 001000 -> ADDI_EXEC; 000010 -> JUMP; any other -> FETCH, with illegal_op=1 for exactly that one cycle.
REQ-021 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state R_WB.
REQ-022 R_WB: reg_dst=1, reg_write=1, mem_to_reg=0; next state FETCH.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_RD for lw, MEM_WR for sw.
REQ-024 MEM_RD: mem_read=1, i_or_d=1; hold while mem_ready=0; go to MEM_WB on mem_ready=1.
REQ-025 MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
REQ-026 MEM_WR: mem_write=1, i_or_d=1; hold while mem_ready=0; go to FETCH on mem_ready=1.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next state FETCH.
REQ-028 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDI_WB.
REQ-029 ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-030 JUMP: pc_write=1, pc_source=10; next state FETCH.
REQ-031 Every output not listed for a state SHALL be 0 in that state; mem_read and mem_write SHALL never both be 1.
REQ-032 The opcode SHALL be sampled only in DECODE and MEM_ADDR; opcode changes in other states SHALL have no effect.
REQ-033 Latency with mem_ready=1 throughout SHALL be: R-type 4 cycles, lw 5, sw 4, addi 4, beq 3, j 3, illegal 2.

Reset
REQ-034 While reset=1 at a rising clock edge, the state SHALL become FETCH regardless of the current state, including mid-wait in MEM_RD or MEM_WR.
REQ-035 While reset=1, all outputs except state SHALL be forced to 0, and state SHALL read the FETCH encoding (0).

Structure
REQ-036 State encodings, opcode constants, and the alu_op, alu_src_b and pc_source codes SHALL live in a shared package, mips_ctrl_pkg.
REQ-037 The module SHALL be a single module with no sub-modules; next-state logic and output decode SHALL be separate always blocks.

Verification
REQ-038 R-type: opcode=000000, mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB, FETCH; reg_write=1 and reg_dst=1 only in R_WB.
REQ-039 lw with mem_ready held low for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles with mem_read=1 and i_or_d=1; total 7 cycles; reg_write=1 with mem_to_reg=1 in MEM_WB.
REQ-040 FETCH with mem_ready=0 for 3 cycles -> ir_write=0 and pc_write=0 for those cycles; ir_write=1 and pc_write=1 in the mem_ready=1 cycle.
REQ-041 beq (000100) -> pc_write_cond=1, alu_op=01, pc_source=01 for exactly one cycle; back in FETCH 3 cycles after entering FETCH.
REQ-042 opcode=111111 -> illegal_op=1 for one cycle in DECODE, no write strobes asserted, FETCH on the next cycle.
REQ-043 reset asserted in MEM_WR with mem_ready=0 -> mem_write=0 in the same cycle; state=FETCH after the edge; normal fetch resumes after reset is released.
